text_rom_streamer: RTL and testbench
====================================

# text_rom_streamer

Responder side of the UI text-display handshake: accepts a message request (`addr`, `length`, `start`) from the menu controller and reads a text ROM. It then streams the message out one ASCII character at a time, with a ready/accept handshake to the display, and pulses `done` after the last character. It sits between the menu FSM and the character display driver, and owns the read port of the message BRAM.

## Interface
- `ADDR_W`, 11: ROM address width and message length width.
- `CHAR_W`, 8: character width.
- `CHAR_GAP`, 4: idle cycles inserted after each accepted character (0 allowed).
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `addr`  in  ADDR_W  ROM address of the first character; sampled on `start`.
- `length`  in  ADDR_W  character count; sampled on `start`; 0 is legal.
- `start`  in  1  single-cycle request strobe.
- `rom_addr`  out  ADDR_W  ROM read address; registered.
- `rom_data`  in  CHAR_W  ROM read data, valid one cycle after `rom_addr`.
- `ascii_out`  out  CHAR_W  current character.
- `ascii_out_ready`  out  1  `ascii_out` valid; held until accepted.
- `sink_ready`  in  1  display accepts the character when high together with `ascii_out_ready`.
- `done`  out  1  one-cycle pulse at end of message.
- `busy`  out  1  high from the cycle after `start` until `done` inclusive.

## Operation
- FSM states: IDLE, FETCH, WAIT, EMIT, GAP, FIN.
- IDLE: on `start`, latch `base=addr`, `remaining=length`, `idx=0`. Go to FIN if `length==0`, else FETCH.
- FETCH: drive `rom_addr = base+idx`, taken mod 2^ADDR_W so it wraps from 2047 to 0. Go to WAIT.
- WAIT: ROM latency cycle. Go to EMIT and capture `rom_data` into `ascii_out` on the transition.
- EMIT: `ascii_out_ready=1`. On `sink_ready`: `idx++`, `remaining--`. If `remaining` becomes 0, go to FIN. Otherwise go to GAP, or go directly to FETCH when `CHAR_GAP==0`.
- GAP: count `CHAR_GAP` cycles, then go to FETCH.
- FIN: `done=1` for exactly one cycle, then go to IDLE.
- `start` in any non-IDLE state aborts the current message:
  - no `done` is issued for the aborted message;
  - `ascii_out_ready` drops the next cycle;
  - the new request is latched exactly as from IDLE.
- `start` takes priority over a simultaneous `sink_ready` acceptance. The aborted character counts as not delivered.
- `ascii_out` holds its value after acceptance until the next capture; it is never cleared except by reset.
- Reset values: all outputs are 0 and the FSM is in IDLE.
- Reset asserted mid-message discards the message; no `done` is issued.

## Timing
- Cycle N: `start` high.
- N+1: FETCH, with `rom_addr=addr` valid at the register output.
- N+2: WAIT.
- N+3: `ascii_out_ready=1` with the first character.
- Sustained rate with `sink_ready` tied high: one character per `3+CHAR_GAP` cycles.
- After the last character is accepted at cycle M: `done=1` at M+1, `busy=0` at M+2.
- `length==0`: `done=1` at N+1 with no characters.
- A new `start` is accepted in the same cycle `done` is high; FIN yields to `start`, so no missed request.
- `busy` is registered and has no combinational path from `start`. `ascii_out_ready` is a registered state decode.

## Structure
- Shared package `ui_text_pkg` holds:
  - the FSM state enum;
  - `ADDR_W`/`CHAR_W` defaults;
  - the message-ROM address constants also used by the menu controller (e.g. `MSG_WELCOME=72`, len 7; `MSG_INCOMING=361`, len 13).
- One natural sub-module: `char_pacer`, the `CHAR_GAP` down-counter with `load`/`expired`. The ROM itself stays outside the block.

## Test plan
- `addr=72, length=7`, ROM preloaded with "Welcome", `sink_ready=1`, `CHAR_GAP=0` -> characters `57 65 6C 63 6F 6D 65` at cycles 3,6,…,21; `done` at 22.
- `length=0` -> `done` at N+1, `ascii_out_ready` never high, `busy` high only at N+1.
- `addr=2046, length=4` -> `rom_addr` sequence 2046, 2047, 0, 1.
- `sink_ready` held low for 10 cycles on character 2 -> `ascii_out` and `ascii_out_ready` stable for those 10 cycles; no skipped or duplicated characters.
- `start` (`addr=361, length=13`) issued during the 3rd character of a 20-char message -> no `done` for the first message; next character is ROM[361] at N+3; 13 characters, then `done`.
- `reset_n` low mid-EMIT -> all outputs 0 immediately (asynchronous); FSM in IDLE; a request after release behaves like the first scenario.

Source files
------------

// File: rtl/ui_text_pkg.sv
// ui_text_pkg: shared UI text types, width defaults and message-ROM map.
package ui_text_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_GAP,
        S_FIN
    } state_t;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_CHAR_W = 8;

    // Message table shared with the menu controller
    localparam int MSG_WELCOME      = 72;
    localparam int MSG_WELCOME_LEN  = 7;
    localparam int MSG_INCOMING     = 361;
    localparam int MSG_INCOMING_LEN = 13;

endpackage

// File: rtl/char_pacer.sv
// char_pacer: counts the idle gap between characters; expired once the load value has run down.
module char_pacer #(
    parameter int GAP = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic expired
);

    localparam int W = GAP > 1 ? $clog2(GAP) : 1;
    localparam logic [W-1:0] INIT = W'(GAP > 0 ? GAP - 1 : 0);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= INIT;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign expired = cnt == '0;

endmodule

// File: rtl/text_rom_streamer.sv
// text_rom_streamer: reads a message from the text ROM and streams it one character
// at a time to the display with a ready/accept handshake, pulsing done at the end.
module text_rom_streamer
    import ui_text_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int CHAR_W   = DEF_CHAR_W,
    parameter int CHAR_GAP = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [CHAR_W-1:0] rom_data,
    output logic [CHAR_W-1:0] ascii_out,
    output logic              ascii_out_ready,
    input  logic              sink_ready,
    output logic              done,
    output logic              busy
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] remaining;
    logic              accept, last, gap_expired;

    // start overrides any acceptance in the same cycle
    assign accept = state == S_EMIT && sink_ready && !start;
    assign last   = remaining == ADDR_W'(1);

    char_pacer #(.GAP(CHAR_GAP)) u_pacer (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (accept && !last),
        .expired(gap_expired)
    );

    always_comb begin
        state_nx = state;
        if (start)
            state_nx = length == '0 ? S_FIN : S_FETCH;
        else
            case (state)
                S_FETCH: state_nx = S_WAIT;
                S_WAIT:  state_nx = S_EMIT;
                S_EMIT:  state_nx = !sink_ready ? S_EMIT : last ? S_FIN : CHAR_GAP == 0 ? S_FETCH : S_GAP;
                S_GAP:   state_nx = gap_expired ? S_FETCH : S_GAP;
                S_FIN:   state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
    end

    // rom_addr doubles as the base+idx pointer, wrapping naturally at 2^ADDR_W
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            rom_addr  <= '0;
            remaining <= '0;
            ascii_out <= '0;
            busy      <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= state_nx != S_IDLE;
            if (start) begin
                rom_addr  <= addr;
                remaining <= length;
            end else if (accept) begin
                rom_addr  <= rom_addr + ADDR_W'(1);
                remaining <= remaining - ADDR_W'(1);
            end
            if (state == S_WAIT && !start)
                ascii_out <= rom_data;
        end
    end

    assign ascii_out_ready = state == S_EMIT;
    assign done            = state == S_FIN;

endmodule

// File: tb/tb_text_rom_streamer.sv
// tb_text_rom_streamer: directed checks of text_rom_streamer with a one-cycle-latency ROM model.
module tb_text_rom_streamer;

    localparam int AW = 11;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          sink_ready = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [AW-1:0] length = '0;
    logic          sel = 1'b0;

    logic [AW-1:0] rom_addr1, rom_addr2, o_rom_addr;
    logic [CW-1:0] rom_data1, rom_data2, ascii1, ascii2, o_ascii;
    logic          rdy1, rdy2, done1, done2, busy1, busy2, o_rdy, o_done, o_busy;

    logic [7:0] rom [0:2047];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        rom_data1 <= rom[rom_addr1];
        rom_data2 <= rom[rom_addr2];
    end

    text_rom_streamer #(.ADDR_W(AW), .CHAR_W(CW), .CHAR_GAP(0)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .length(length), .start(start),
        .rom_addr(rom_addr1), .rom_data(rom_data1), .ascii_out(ascii1),
        .ascii_out_ready(rdy1), .sink_ready(sink_ready), .done(done1), .busy(busy1)
    );

    text_rom_streamer #(.ADDR_W(AW), .CHAR_W(CW), .CHAR_GAP(2)) dut_gap (
        .clk(clk), .reset_n(reset_n), .addr(addr), .length(length), .start(start),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .ascii_out(ascii2),
        .ascii_out_ready(rdy2), .sink_ready(sink_ready), .done(done2), .busy(busy2)
    );

    assign o_rom_addr = sel ? rom_addr2 : rom_addr1;
    assign o_ascii    = sel ? ascii2 : ascii1;
    assign o_rdy      = sel ? rdy2 : rdy1;
    assign o_done     = sel ? done2 : done1;
    assign o_busy     = sel ? busy2 : busy1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rom_addr"}, 32'(rom_addr1), 0);
        check({tag, "_ascii"}, 32'(ascii1), 0);
        check({tag, "_rdy"}, 32'(rdy1), 0);
        check({tag, "_done"}, 32'(done1), 0);
        check({tag, "_busy"}, 32'(busy1), 0);
    endtask

    // Issue start in the current cycle, then follow the message to its done pulse.
    task automatic run_msg(input logic [AW-1:0] a, input logic [AW-1:0] l, input int gap,
                           input int st_from, input int st_to, input int done_at);
        int k = 0;
        int fetch_at = 1;
        bit seen = 0;
        logic [AW-1:0] ea;
        addr = a;
        length = l;
        start = 1'b1;
        sink_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t <= done_at + 1; t++) begin
            sink_ready = !(t >= st_from && t < st_to);
            ea = a + AW'(k);
            if (t == 1) begin
                check("busy_on", 32'(o_busy), 1);
                check("rdy_first", 32'(o_rdy), 0);
            end
            if (t == fetch_at && k < int'(l))
                check("rom_addr", 32'(o_rom_addr), 32'(ea));
            if (t >= st_from && t < st_to)
                check("stall_rdy", 32'(o_rdy), 1);
            if (o_rdy) begin
                check("in_len", 32'(k < int'(l)), 1);
                check("char", 32'(o_ascii), 32'(rom[ea]));
                if (sink_ready) begin
                    k++;
                    fetch_at = t + 1 + gap;
                end
            end
            if (o_done) begin
                check("done_at", t, done_at);
                check("count", k, 32'(l));
                seen = 1;
            end
            if (t == done_at + 1)
                check("busy_off", 32'(o_busy), 0);
            tick();
        end
        check("done_seen", 32'(seen), 1);
    endtask

    initial begin
        string welcome, incoming;
        welcome = "Welcome";
        incoming = "Incoming call";
        for (int i = 0; i < 2048; i++)
            rom[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 7; i++)
            rom[72 + i] = welcome[i];
        for (int i = 0; i < 13; i++)
            rom[361 + i] = incoming[i];
        for (int i = 0; i < 20; i++)
            rom[500 + i] = 8'(65 + i);

        tick();
        tick();
        check_zero("reset");
        reset_n = 1'b1;
        tick();

        run_msg(11'd72, 11'd7, 0, 0, 0, 22);
        sel = 1'b1;
        run_msg(11'd72, 11'd7, 2, 0, 0, 34);
        sel = 1'b0;
        run_msg(11'd100, 11'd0, 0, 0, 0, 1);
        run_msg(11'd2046, 11'd4, 0, 0, 0, 13);
        run_msg(11'd72, 11'd7, 0, 6, 16, 32);

        addr = 11'd500;
        length = 11'd20;
        start = 1'b1;
        sink_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t < 9; t++) begin
            check("abort_nodone", 32'(done1), 0);
            tick();
        end
        check("abort_rdy", 32'(rdy1), 1);
        check("abort_char", 32'(ascii1), 32'(rom[502]));
        run_msg(11'd361, 11'd13, 0, 0, 0, 40);

        addr = 11'd72;
        length = 11'd7;
        sink_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_reset_rdy", 32'(rdy1), 1);
        #2 reset_n = 1'b0;
        #1 check_zero("async_reset");
        tick();
        reset_n = 1'b1;
        tick();
        run_msg(11'd72, 11'd7, 0, 0, 0, 22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
